// File: rtl/alu_matrix_seq_engine.sv
// alu_matrix_seq_engine: element-serial NxN signed matrix ALU with a shared adder/MAC datapath
module alu_matrix_seq_engine #(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [W-1:0]     scalar,
  input  logic [N*N*W-1:0] A_flat,
  input  logic [N*N*W-1:0] B_flat,
  output logic [N*N*W-1:0] C_flat,
  output logic             overflow_flag,
  output logic             error_flag,
  output logic             busy,
  output logic             done
);
  localparam int IW = $clog2(N);
  localparam int AW = 2 * W + $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [N*N*W-1:0] a_q, b_q;
  logic [2:0] op_q;
  logic [W-1:0] sc_q;
  logic [IW-1:0] i, j, m;
  logic signed [AW-1:0] acc, acc_next, prod, res, xa, xb, xt, xs;
  int k, kt, ka, kb;
  logic is_mul, wr, last, ovf_e, rsv;
  // shared datapath: operand selection, adder/MAC and wrap/overflow detection for the current element
  always_comb begin
    k = int'(i) * N + int'(j);
    kt = int'(j) * N + int'(i);
    ka = int'(i) * N + int'(m);
    kb = int'(m) * N + int'(j);
    xa = AW'($signed(a_q[k*W +: W]));
    xb = AW'($signed(b_q[k*W +: W]));
    xt = AW'($signed(a_q[kt*W +: W]));
    xs = AW'($signed(sc_q));
    prod = AW'($signed(a_q[ka*W +: W])) * AW'($signed(b_q[kb*W +: W]));
    acc_next = (m == '0 ? '0 : acc) + prod;
    is_mul = op_q == 3'b011;
    res = op_q == 3'b001 ? xa + xb :
          op_q == 3'b010 ? xa - xb :
          is_mul         ? acc_next :
          op_q == 3'b100 ? -xa :
          op_q == 3'b101 ? xt : xa * xs;
    ovf_e = res != AW'($signed(res[W-1:0]));
    wr = !is_mul || m == LAST;
    last = wr && i == LAST && j == LAST;
    rsv = opcode == 3'b000 || opcode == 3'b111;
  end
  // control FSM: accept/latch, walk elements (and MAC terms), publish with a one-cycle done pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      sc_q <= '0;
      i <= '0;
      j <= '0;
      m <= '0;
      acc <= '0;
      C_flat <= '0;
      overflow_flag <= 1'b0;
      error_flag <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (state != RUN && start) begin
      a_q <= A_flat;
      b_q <= B_flat;
      op_q <= opcode;
      sc_q <= scalar;
      i <= '0;
      j <= '0;
      m <= '0;
      acc <= '0;
      C_flat <= '0;
      overflow_flag <= 1'b0;
      error_flag <= rsv;
      busy <= !rsv;
      done <= rsv;
      state <= rsv ? DONE : RUN;
    end else if (state == RUN) begin
      acc <= acc_next;
      m <= (is_mul && m != LAST) ? m + 1'b1 : '0;
      if (wr) begin
        C_flat[k*W +: W] <= res[W-1:0];
        overflow_flag <= overflow_flag | ovf_e;
        j <= j == LAST ? '0 : j + 1'b1;
        i <= j == LAST ? i + 1'b1 : i;
      end
      if (last) begin
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      state <= IDLE;
      done <= 1'b0;
    end
  end
endmodule

// File: doc/alu_matrix_seq_engine.md
Name: alu_matrix_seq_engine

Overview:
- Parametrised, sequential successor of the matrix ALU: square NxN matrices of W-bit signed two's-complement elements, row-major flattened.
- Operands are latched on a start handshake and results computed element-serially with one shared adder/MAC datapath.
- C_flat, overflow_flag and error_flag are held until the next accepted start, with a one-cycle done pulse.
- Sits between the instruction decoder / operand bank and the result register bank.

Parameters:
- N, 5, matrix dimension (rows = cols), 2..8.
- W, 8, element width in bits, 4..16.

Ports:
- clock  in  1  rising-edge system clock.
- reset_n  in  1  reset, asynchronous and active-low.
- start  in  1  request; accepted only in IDLE or DONE.
- opcode  in  3  001 sum, 010 sub, 011 mul, 100 opposite, 101 transpose, 110 scalar, 000/111 reserved.
- scalar  in  W  signed scalar for opcode 110.
- A_flat  in  N*N*W  operand A; element (i,j) at [(i*N+j)*W +: W].
- B_flat  in  N*N*W  operand B, same layout.
- C_flat  out  N*N*W  result, same layout.
- overflow_flag  out  1  sticky over the operation; set if any element result is not representable in signed W bits.
- error_flag  out  1  reserved opcode was issued.
- busy  out  1  high while computing.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; C_flat=0, overflow_flag=0, error_flag=0, busy=0, done=0; internal counters and accumulator cleared.
- Reset mid-operation aborts immediately, with no done pulse.
- States: IDLE, RUN, DONE.
- Accept:
  - start=1 in IDLE or DONE at edge T latches A, B, opcode and scalar.
  - It clears C_flat, overflow_flag and error_flag, then enters RUN; busy=1 from T+1.
  - start while busy is ignored, and the latched operands are unaffected by input changes.
- Reserved opcode: no RUN; goes to DONE at T+1 with done=1, error_flag=1, C_flat=0, overflow_flag=0.
- Element index: k = i*N+j, walked 0..N*N-1. One element written per compute step.
- Elementwise ops (K = N*N compute cycles):
  - sum: A+B.
  - sub: A-B.
  - opposite: 0-A.
  - transpose: C(i,j)=A(j,i), never overflows.
  - scalar: A*scalar.
  - The full-precision result (W+1 bits, or 2W for scalar) is truncated to W bits (wrap).
  - overflow_flag |= (full result outside [-2^(W-1), 2^(W-1)-1]).
- mul (K = N*N*N compute cycles):
  - Per element, N MAC cycles: acc += A(i,m)*B(m,j), m=0..N-1.
  - acc is 2W+clog2(N) bits, cleared at each element start.
  - After the m=N-1 cycle, C(i,j)=acc[W-1:0] and the overflow check applies to acc.
- Timing:
  - Compute cycles occupy T+1..T+K; busy=1 during exactly these cycles.
  - At T+K+1: state=DONE, busy=0, done=1 for one cycle, C_flat final.
  - DONE falls back to IDLE after one cycle unless a new start is accepted.
  - Back-to-back operation: start asserted in the DONE cycle is accepted, so busy rises next cycle.
- Intermediate C_flat contents during RUN are not guaranteed; consumers sample only on done.
- Outputs otherwise hold their values indefinitely.

Test Plan:
1. N=5, W=8, sum, A all 100, B all 30, start at T -> busy T+1..T+25, done at T+26; every C element 0x82; overflow_flag=1; error_flag=0.
2. mul, A=identity, B element k = k (0..24) -> done at T+126; C_flat==B_flat; overflow_flag=0. Repeat with A all 16, B all 16 -> each element 1280 truncated to 0x00, overflow_flag=1.
3. opposite, A element 0 = 0x80 (-128), others 0x05 -> C(0,0)=0x80, others 0xFB; overflow_flag=1. transpose, A(i,j)=i*5+j -> C(i,j)=j*5+i; overflow_flag=0; done at T+26.
4. scalar=-3 (0xFD), A all 0x0A -> every element 0xE2 (-30); overflow_flag=0. scalar=0x7F, A all 2 -> every element 0xFE; overflow_flag=1.
5. Opcode 111, then opcode 000 -> each gives done at T+1, error_flag=1, C_flat=0, busy never high. Next valid sum clears error_flag.
6. Control corners:
   - start pulsed at T+10 during a sum: ignored, done still at T+26.
   - start held in the DONE cycle with new operands: second operation begins and busy rises at T+27.
   - reset_n low at T+50 of a mul: all outputs 0 immediately, no done pulse; a later start behaves normally.
